zap_btb_assoc: RTL and testbench

//  Set-associative branch target buffer; the next generation after the direct-mapped BTB in the fetch stage.
//  - Predicts fetch-PC redirects one cycle after lookup, using a 2-bit counter and a stored 32-bit target.
//  - Parametrised in depth and associativity.
//  - Replacement per set: first invalid way, otherwise round-robin.
//  - Outputs the hit way, so the pipeline can return it with feedback. No write-side tag search is needed.

---
 rtl/zap_btb_pkg.sv | 36 +++
 rtl/zap_btb_way.sv | 39 +++
 rtl/zap_ram_simple_nopipe.sv | 20 ++
 rtl/zap_btb_assoc.sv | 141 ++++++++++++++
 tb/tb_zap_btb_assoc.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/zap_btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
package zap_btb_pkg;

  typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} bstate_t;

  // The tag field is sized for the smallest legal index (IDX_W=1); ways store only TAG_WDT bits.
  typedef struct packed {
    logic [31:0] target;
    logic [29:0] tag;
    logic [1:0]  state;
  } btb_entry_t;

  function automatic logic [1:0] compute(input logic [1:0] st, input logic nok);
    logic [1:0] r;
    if (nok) begin
      case (st)
        SNT:     r = WNT;
        WNT:     r = WT;
        WT:      r = WNT;
        default: r = WT;
      endcase
    end else begin
      r = st[1] ? ST : SNT;
    end
    return r;
  endfunction

  function automatic logic [2:0] first_invalid(input logic [7:0] inv);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (inv[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/zap_btb_way.sv
// One BTB way: entry RAM plus tag compare against the delayed lookup PC.
module zap_btb_way
  import zap_btb_pkg::*;
#(
  parameter int SETS    = 512,
  parameter int TAG_WDT = 22
) (
  input  logic                     i_clk,
  input  logic                     rd_en,
  input  logic [$clog2(SETS)-1:0]  rd_idx,
  input  logic [TAG_WDT-1:0]       cmp_tag,
  input  logic                     wr_en,
  input  logic [$clog2(SETS)-1:0]  wr_idx,
  input  btb_entry_t               wr_entry,
  output logic                     tag_match,
  output logic [1:0]               state,
  output logic [31:0]              target
);
  localparam int W = 34 + TAG_WDT;

  logic [W-1:0] rd_word;
  logic         unused_tag;

  assign unused_tag = ^{1'b0, wr_entry.tag};

  zap_ram_simple_nopipe #(.DEPTH(SETS), .WIDTH(W)) u_ram (
    .i_clk   (i_clk),
    .rd_en   (rd_en),
    .rd_addr (rd_idx),
    .rd_data (rd_word),
    .wr_en   (wr_en),
    .wr_addr (wr_idx),
    .wr_data ({wr_entry.target, wr_entry.tag[TAG_WDT-1:0], wr_entry.state})
  );

  assign target    = rd_word[W-1 -: 32];
  assign state     = rd_word[1:0];
  assign tag_match = (rd_word[TAG_WDT+1:2] == cmp_tag);
endmodule

// File: rtl/zap_ram_simple_nopipe.sv
// Single-clock simple dual-port RAM; registered read returns pre-write data on collision.
module zap_ram_simple_nopipe #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/zap_btb_assoc.sv
// Set-associative BTB: 1-cycle lookup, lowest-way hit priority, invalid-first then round-robin fill.
module zap_btb_assoc
  import zap_btb_pkg::*;
#(
  parameter  int BP_ENTRIES = 1024,
  parameter  int WAYS       = 2,
  localparam int SETS       = BP_ENTRIES / WAYS,
  localparam int IDX_W      = $clog2(SETS),
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int TAG_WDT    = 31 - IDX_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_clear,
  input  logic             i_fb_ok,
  input  logic             i_fb_nok,
  input  logic             i_fb_hit,
  input  logic [WAY_W-1:0] i_fb_way,
  input  logic [31:0]      i_fb_branch_src_address,
  input  logic [1:0]       i_fb_current_branch_state,
  input  logic [31:0]      i_fb_branch_dest_address,
  input  logic [31:0]      i_rd_addr,
  input  logic [31:0]      i_rd_addr_del,
  output logic             o_clear_from_btb,
  output logic [31:0]      o_pc_from_btb,
  output logic [1:0]       o_branch_state,
  output logic             o_hit,
  output logic [WAY_W-1:0] o_hit_way
);
  logic [SETS-1:0][WAYS-1:0]  valid;
  logic [SETS-1:0][WAY_W-1:0] rr_ptr;
  logic [WAYS-1:0]            valid_q, tag_match;
  logic [WAYS-1:0][1:0]       way_state;
  logic [WAYS-1:0][31:0]      way_target;

  logic [IDX_W-1:0]   rd_idx, fb_idx;
  logic [TAG_WDT-1:0] del_tag, fb_tag;
  logic               unused_bits;

  assign rd_idx      = i_rd_addr[IDX_W:1];
  assign fb_idx      = i_fb_branch_src_address[IDX_W:1];
  assign del_tag     = i_rd_addr_del[31:IDX_W+1];
  assign fb_tag      = i_fb_branch_src_address[31:IDX_W+1];
  assign unused_bits = ^{i_rd_addr[0], i_rd_addr[31:IDX_W+1], i_rd_addr_del[IDX_W:0],
                         i_fb_branch_src_address[0]};

  logic             upd, alloc, all_valid;
  logic [7:0]       inv8;
  logic [WAY_W-1:0] victim, wr_way, rr_nxt;
  btb_entry_t       wr_entry;

  always_comb begin
    upd       = (i_fb_ok | i_fb_nok) & i_fb_hit;
    alloc     = i_fb_nok & ~i_fb_hit;
    inv8      = '0;
    inv8[WAYS-1:0] = ~valid[fb_idx];
    all_valid = &valid[fb_idx];
    victim    = all_valid ? rr_ptr[fb_idx] : WAY_W'(first_invalid(inv8));
    rr_nxt    = (WAYS == 1) ? '0 : rr_ptr[fb_idx] + WAY_W'(1);
    wr_way    = upd ? i_fb_way : victim;
    wr_entry.target = i_fb_branch_dest_address;
    wr_entry.tag    = 30'(fb_tag);
    wr_entry.state  = upd ? compute(i_fb_current_branch_state, i_fb_nok) : WT;
  end

  // Clear beats a same-cycle write: the RAM may take the data but the valid bit stays low.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      valid  <= '0;
      rr_ptr <= '0;
    end else if (upd || alloc) begin
      valid[fb_idx][wr_way] <= 1'b1;
      if (alloc && all_valid) rr_ptr[fb_idx] <= rr_nxt;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    zap_btb_way #(.SETS(SETS), .TAG_WDT(TAG_WDT)) u_way (
      .i_clk     (i_clk),
      .rd_en     (!i_stall),
      .rd_idx    (rd_idx),
      .cmp_tag   (del_tag),
      .wr_en     (!i_reset && (upd || alloc) && (wr_way == WAY_W'(w))),
      .wr_idx    (fb_idx),
      .wr_entry  (wr_entry),
      .tag_match (tag_match[w]),
      .state     (way_state[w]),
      .target    (way_target[w])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) valid_q <= '0;
    else if (!i_stall)      valid_q <= valid[rd_idx];
  end

  logic             hit_any, take;
  logic [WAY_W-1:0] sel_way;
  logic [1:0]       sel_state;
  logic [31:0]      sel_target;

  always_comb begin
    hit_any    = 1'b0;
    sel_way    = '0;
    sel_state  = SNT;
    sel_target = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w] && tag_match[w]) begin
        hit_any    = 1'b1;
        sel_way    = WAY_W'(w);
        sel_state  = way_state[w];
        sel_target = way_target[w];
      end
    end
  end

  assign take = hit_any & sel_state[1] & ~i_clear;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_hit            <= 1'b0;
      o_hit_way        <= '0;
      o_branch_state   <= SNT;
      o_clear_from_btb <= 1'b0;
      o_pc_from_btb    <= '0;
    end else begin
      if (!i_stall) begin
        o_hit            <= hit_any & ~i_clear;
        o_hit_way        <= sel_way;
        o_branch_state   <= sel_state;
        o_clear_from_btb <= take;
        if (take) o_pc_from_btb <= sel_target;
      end
      if (i_clear) begin
        o_hit            <= 1'b0;
        o_clear_from_btb <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_zap_btb_assoc.sv
// Directed bench for zap_btb_assoc with WAYS=2, BP_ENTRIES=8 (index [2:1], tag [31:3]).
module tb_zap_btb_assoc;
  import zap_btb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, clr, fb_ok, fb_nok, fb_hit, fb_way;
  logic [1:0]  fb_st;
  logic [31:0] fb_src, fb_dest, rd_addr, rd_addr_del;
  logic        o_clr, o_hit, o_way;
  logic [31:0] o_pc;
  logic [1:0]  o_st;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  zap_btb_assoc #(.BP_ENTRIES(8), .WAYS(2)) dut (
    .i_clk                     (clk),
    .i_reset                   (rst),
    .i_stall                   (stall),
    .i_clear                   (clr),
    .i_fb_ok                   (fb_ok),
    .i_fb_nok                  (fb_nok),
    .i_fb_hit                  (fb_hit),
    .i_fb_way                  (fb_way),
    .i_fb_branch_src_address   (fb_src),
    .i_fb_current_branch_state (fb_st),
    .i_fb_branch_dest_address  (fb_dest),
    .i_rd_addr                 (rd_addr),
    .i_rd_addr_del             (rd_addr_del),
    .o_clear_from_btb          (o_clr),
    .o_pc_from_btb             (o_pc),
    .o_branch_state            (o_st),
    .o_hit                     (o_hit),
    .o_hit_way                 (o_way)
  );

  typedef struct {
    logic        ok, nok, hit, way;
    logic [1:0]  st;
    logic [31:0] src, dest, look;
    logic        e_hit, e_way;
    logic [1:0]  e_st;
    logic        e_clr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t v[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic h, input logic w, input logic [1:0] s,
                           input logic c, input logic [31:0] pc);
    check({tag, " hit"},   32'(o_hit), 32'(h));
    check({tag, " way"},   32'(o_way), 32'(w));
    check({tag, " state"}, 32'(o_st),  32'(s));
    check({tag, " clr"},   32'(o_clr), 32'(c));
    check({tag, " pc"},    o_pc,       pc);
  endtask

  task automatic fb(input logic ok, input logic nok, input logic hit, input logic way,
                    input logic [1:0] st, input logic [31:0] src, input logic [31:0] dest);
    fb_ok = ok; fb_nok = nok; fb_hit = hit; fb_way = way;
    fb_st = st; fb_src = src; fb_dest = dest;
    step();
    fb_ok = 1'b0; fb_nok = 1'b0; fb_hit = 1'b0;
  endtask

  // Read edge then compare edge; outputs are valid after the second edge.
  task automatic lookup(input logic [31:0] a);
    rd_addr = a;
    step();
    rd_addr_del = a;
    step();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; clr = 1'b0;
    fb_ok = 1'b0; fb_nok = 1'b0; fb_hit = 1'b0; fb_way = 1'b0; fb_st = SNT;
    fb_src = '0; fb_dest = '0; rd_addr = '0; rd_addr_del = '0;

    //       ok nok hit way st   src        dest       look       eh ew es   ec pc
    v[0]  = '{0, 1, 0, 0, SNT, 32'h100, 32'h400, 32'h100, 1, 0, WT,  1, 32'h400};
    v[1]  = '{0, 1, 0, 0, SNT, 32'h120, 32'h500, 32'h120, 1, 1, WT,  1, 32'h500};
    v[2]  = '{0, 1, 0, 0, SNT, 32'h140, 32'h600, 32'h140, 1, 0, WT,  1, 32'h600};
    v[3]  = '{0, 0, 0, 0, SNT, 32'h0,   32'h0,   32'h100, 0, 0, SNT, 0, 32'h600};
    v[4]  = '{1, 0, 1, 1, WT,  32'h120, 32'h500, 32'h120, 1, 1, ST,  1, 32'h500};
    v[5]  = '{0, 1, 1, 1, ST,  32'h120, 32'h520, 32'h120, 1, 1, WT,  1, 32'h520};
    v[6]  = '{0, 1, 1, 1, WT,  32'h120, 32'h520, 32'h120, 1, 1, WNT, 0, 32'h520};
    v[7]  = '{0, 1, 0, 0, SNT, 32'h100, 32'h700, 32'h100, 1, 1, WT,  1, 32'h700};
    v[8]  = '{0, 0, 0, 0, SNT, 32'h0,   32'h0,   32'h120, 0, 0, SNT, 0, 32'h700};
    v[9]  = '{1, 0, 0, 0, SNT, 32'h160, 32'h999, 32'h160, 0, 0, SNT, 0, 32'h700};
    v[10] = '{0, 1, 0, 0, SNT, 32'h102, 32'h800, 32'h102, 1, 0, WT,  1, 32'h800};
    v[11] = '{0, 0, 0, 0, SNT, 32'h0,   32'h0,   32'h101, 1, 1, WT,  1, 32'h700};
    v[12] = '{1, 0, 1, 0, WNT, 32'h102, 32'h800, 32'h102, 1, 0, SNT, 0, 32'h700};
    v[13] = '{0, 1, 1, 0, SNT, 32'h102, 32'h800, 32'h102, 1, 0, WNT, 0, 32'h700};
    v[14] = '{0, 1, 1, 0, WNT, 32'h102, 32'h800, 32'h102, 1, 0, WT,  1, 32'h800};
    v[15] = '{1, 0, 1, 0, WT,  32'h102, 32'h800, 32'h102, 1, 0, ST,  1, 32'h800};
    v[16] = '{1, 1, 1, 0, WT,  32'h102, 32'h800, 32'h102, 1, 0, WNT, 0, 32'h800};

    step(); step();
    rst = 1'b0;
    check_out("reset", 0, 0, SNT, 0, 32'h0);
    lookup(32'h100);
    check_out("empty", 0, 0, SNT, 0, 32'h0);

    for (int i = 0; i < 17; i++) begin
      if (v[i].ok || v[i].nok)
        fb(v[i].ok, v[i].nok, v[i].hit, v[i].way, v[i].st, v[i].src, v[i].dest);
      lookup(v[i].look);
      check_out($sformatf("v%0d", i), v[i].e_hit, v[i].e_way, v[i].e_st, v[i].e_clr, v[i].e_pc);
    end

    // Stall: outputs hold while a new PC is presented and a feedback write lands.
    lookup(32'h100);
    check_out("pre_stall", 1, 1, WT, 1, 32'h700);
    stall = 1'b1;
    rd_addr = 32'h104;
    fb_nok = 1'b1; fb_hit = 1'b0; fb_src = 32'h104; fb_dest = 32'h900;
    for (int c = 0; c < 3; c++) begin
      step();
      fb_nok = 1'b0;
      check_out($sformatf("stall%0d", c), 1, 1, WT, 1, 32'h700);
    end
    stall = 1'b0;
    step();
    check_out("release", 1, 1, WT, 1, 32'h700);
    rd_addr_del = 32'h104;
    step();
    check_out("stall_wr", 1, 0, WT, 1, 32'h900);

    // Same-set read and write in one cycle: the read sees the old entry.
    rd_addr = 32'h140;
    fb_nok = 1'b1; fb_hit = 1'b1; fb_way = 1'b0; fb_st = WT; fb_src = 32'h140; fb_dest = 32'hA00;
    step();
    fb_nok = 1'b0; fb_hit = 1'b0;
    rd_addr_del = 32'h140;
    step();
    check_out("rw_old", 1, 0, WT, 1, 32'h600);
    lookup(32'h140);
    check_out("rw_new", 1, 0, WNT, 0, 32'h600);

    // Clear with a same-cycle allocate: outputs forced low, entry stays invalid.
    lookup(32'h100);
    check_out("pre_clr", 1, 1, WT, 1, 32'h700);
    clr = 1'b1;
    fb_nok = 1'b1; fb_hit = 1'b0; fb_src = 32'h180; fb_dest = 32'hB00;
    step();
    clr = 1'b0; fb_nok = 1'b0;
    check("clr hit", 32'(o_hit), 32'd0);
    check("clr clr", 32'(o_clr), 32'd0);
    lookup(32'h180);
    check("clr 180 hit", 32'(o_hit), 32'd0);
    lookup(32'h100);
    check("clr 100 hit", 32'(o_hit), 32'd0);
    lookup(32'h104);
    check("clr 104 hit", 32'(o_hit), 32'd0);

    // Rebuild set0 after clear; round-robin pointer must be back at way0.
    fb(0, 1, 0, 0, SNT, 32'h100, 32'h400);
    fb(0, 1, 0, 0, SNT, 32'h120, 32'h500);
    fb(0, 1, 0, 0, SNT, 32'h140, 32'h600);
    lookup(32'h140);
    check_out("refill", 1, 0, WT, 1, 32'h600);
    lookup(32'h120);
    check_out("refill_w1", 1, 1, WT, 1, 32'h500);

    // Reset with a same-cycle allocate: nothing becomes valid.
    rst = 1'b1;
    fb_nok = 1'b1; fb_hit = 1'b0; fb_src = 32'h106; fb_dest = 32'hC00;
    step();
    rst = 1'b0; fb_nok = 1'b0;
    check_out("rst2", 0, 0, SNT, 0, 32'h0);
    lookup(32'h106);
    check_out("rst_fb", 0, 0, SNT, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
